// File: rtl/out_reg_fifo.sv
// ============================================================================
//  Module      : out_reg_fifo
//  Description : Change-capturing FIFO between the CPU output register and
//                the serializer, with valid/ready output and overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_reg_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  sample_q;
    logic [WIDTH-1:0]  last_q;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;

    logic push;
    logic pop;
    logic full;
    logic wr_en;

    assign full  = (count_q == FULL_COUNT);
    assign push  = (sample_q != last_q) && !flush;
    assign pop   = (count_q != '0) && out_ready && !flush;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign wr_en = push && (!full || pop);

    assign out_valid = (count_q != '0);
    assign out_data  = mem[rd_ptr];
    assign count     = count_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            last_q   <= '0;
        end else begin
            sample_q <= data_in;
            last_q   <= sample_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
